// File: rtl/dim_send_scheduler_pkg.sv
// Shared constants, FSM encoding and priority-candidate helper for the
// dimension send scheduler.
package dim_send_scheduler_pkg;

    localparam int NBUF    = 7;
    localparam int NDIM    = 12;
    localparam int PRI_W   = 3;
    localparam int DIM_W   = 4;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    localparam logic [IDX_W-1:0] IDX_NONE = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PICK  = 2'd1,
        S_OFFER = 2'd2,
        S_ADV   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [PRI_W-1:0] pri;
        logic [IDX_W-1:0] idx;
    } cand_t;

    // Left operand wins ties, so lower slot indices take precedence.
    function automatic cand_t cand_max(cand_t l, cand_t r);
        return (l.pri >= r.pri) ? l : r;
    endfunction

endpackage

// File: rtl/dim_send_scheduler_if.sv
// Buffer-side inputs, link handshake and clear/status outputs of the
// dimension send scheduler.
interface dim_send_scheduler_if;
    import dim_send_scheduler_pkg::*;

    logic                    en;
    logic [NBUF:1]           buf_valid;
    logic [NBUF*PRI_W-1:0]   buf_pri;
    logic [NBUF*NDIM-1:0]    buf_addr;
    logic                    send_ready;
    logic [DIM_W-1:0]        cur_dim;
    logic                    send_valid;
    logic [IDX_W-1:0]        send_buf;
    logic                    clr_valid;
    logic [IDX_W-1:0]        clr_buf;
    logic [DIM_W-1:0]        clr_dim;
    logic                    blocked;
    logic                    cycle_done;

    modport master (
        input  en, buf_valid, buf_pri, buf_addr, send_ready,
        output cur_dim, send_valid, send_buf, clr_valid, clr_buf, clr_dim,
               blocked, cycle_done
    );

    modport slave (
        output en, buf_valid, buf_pri, buf_addr, send_ready,
        input  cur_dim, send_valid, send_buf, clr_valid, clr_buf, clr_dim,
               blocked, cycle_done
    );

endinterface

// File: rtl/dim_send_scheduler_pick_tree.sv
// Combinational selector: masks buffer priorities by the current dimension
// and returns the highest-priority index through a 3-level compare tree.
module dim_pick_tree
    import dim_send_scheduler_pkg::*;
(
    input  logic [NBUF:1]         buf_valid_i,
    input  logic [NBUF*PRI_W-1:0] buf_pri_i,
    input  logic [NBUF*NDIM-1:0]  buf_addr_i,
    input  logic [DIM_W-1:0]      cur_dim_i,
    output logic [IDX_W-1:0]      sel_o
);

    cand_t slot [8];
    cand_t l1   [4];
    cand_t l2   [2];
    cand_t win;

    // Slot 0 is the permanent "none" candidate with priority 0.
    assign slot[0] = '{pri: '0, idx: IDX_NONE};

    for (genvar g = 1; g <= NBUF; g++) begin : g_slot
        logic [NDIM-1:0] addr;
        assign addr    = buf_addr_i[(g-1)*NDIM +: NDIM];
        assign slot[g] = '{pri: (buf_valid_i[g] && addr[cur_dim_i]) ?
                                buf_pri_i[(g-1)*PRI_W +: PRI_W] : '0,
                           idx: IDX_W'(g)};
    end

    for (genvar g = 0; g < 4; g++) begin : g_l1
        assign l1[g] = cand_max(slot[2*g], slot[2*g+1]);
    end

    assign l2[0] = cand_max(l1[0], l1[1]);
    assign l2[1] = cand_max(l1[2], l1[3]);
    assign win   = cand_max(l2[0], l2[1]);
    assign sel_o = (win.pri == '0) ? IDX_NONE : win.idx;

endmodule

// File: rtl/dim_send_scheduler.sv
// Dimension-cycle scheduler: walks cur_dim 0..NDIM-1, offers the best
// eligible buffer per dimension and requests an address-bit clear on transfer.
module dim_send_scheduler
    import dim_send_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    dim_send_scheduler_if.master bus
);

    sched_state_t     state_q, state_d;
    logic [DIM_W-1:0] cur_dim_q, cur_dim_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             send_valid_q, send_valid_d;
    logic [IDX_W-1:0] send_buf_q, send_buf_d;
    logic             clr_valid_q, clr_valid_d;
    logic [IDX_W-1:0] clr_buf_q, clr_buf_d;
    logic [DIM_W-1:0] clr_dim_q, clr_dim_d;
    logic             blocked_q, blocked_d;
    logic             cycle_done_q, cycle_done_d;
    logic [IDX_W-1:0] pick_idx;
    logic [NBUF:0]    valid_ext;

    assign valid_ext = {bus.buf_valid, 1'b0};

    dim_pick_tree u_pick (
        .buf_valid_i (bus.buf_valid),
        .buf_pri_i   (bus.buf_pri),
        .buf_addr_i  (bus.buf_addr),
        .cur_dim_i   (cur_dim_q),
        .sel_o       (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        cur_dim_d    = cur_dim_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        clr_valid_d  = 1'b0;
        clr_buf_d    = IDX_NONE;
        clr_dim_d    = '0;
        blocked_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.en) state_d = S_PICK;
            end
            S_PICK: begin
                sel_d   = pick_idx;
                cnt_d   = CNT_W'(TIMEOUT - 1);
                state_d = (pick_idx != IDX_NONE) ? S_OFFER : S_ADV;
            end
            S_OFFER: begin
                // Ready takes precedence over a same-cycle valid drop.
                if (bus.send_ready) begin
                    state_d     = S_ADV;
                    clr_valid_d = 1'b1;
                    clr_buf_d   = sel_q;
                    clr_dim_d   = cur_dim_q;
                end else if (!valid_ext[sel_q]) begin
                    state_d = S_ADV;
                end else if (cnt_q == '0) begin
                    state_d   = S_ADV;
                    blocked_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADV: begin
                cur_dim_d = (cur_dim_q == DIM_W'(NDIM - 1)) ? '0 : cur_dim_q + 1'b1;
                state_d   = bus.en ? S_PICK : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        send_valid_d = (state_d == S_OFFER);
        send_buf_d   = send_valid_d ? sel_d : IDX_NONE;
        cycle_done_d = (state_d == S_ADV) && (cur_dim_q == DIM_W'(NDIM - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_dim_q    <= '0;
            sel_q        <= IDX_NONE;
            cnt_q        <= '0;
            send_valid_q <= 1'b0;
            send_buf_q   <= IDX_NONE;
            clr_valid_q  <= 1'b0;
            clr_buf_q    <= IDX_NONE;
            clr_dim_q    <= '0;
            blocked_q    <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_dim_q    <= cur_dim_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            send_valid_q <= send_valid_d;
            send_buf_q   <= send_buf_d;
            clr_valid_q  <= clr_valid_d;
            clr_buf_q    <= clr_buf_d;
            clr_dim_q    <= clr_dim_d;
            blocked_q    <= blocked_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign bus.cur_dim    = cur_dim_q;
    assign bus.send_valid = send_valid_q;
    assign bus.send_buf   = send_buf_q;
    assign bus.clr_valid  = clr_valid_q;
    assign bus.clr_buf    = clr_buf_q;
    assign bus.clr_dim    = clr_dim_q;
    assign bus.blocked    = blocked_q;
    assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_dim_send_scheduler.sv
// Bench for dim_send_scheduler: directed scenarios plus randomized dimension
// visits checked against a buffer-store model and a priority-rule picker.
module tb_dim_send_scheduler;
    import dim_send_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bit         m_valid [1:NBUF];
    logic [2:0] m_pri   [1:NBUF];
    logic [11:0] m_addr [1:NBUF];
    int         m_dim;

    dim_send_scheduler_if bus ();

    dim_send_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 1; i <= NBUF; i++) begin
            bus.buf_valid[i]                   = m_valid[i];
            bus.buf_pri[(i-1)*PRI_W +: PRI_W]  = m_pri[i];
            bus.buf_addr[(i-1)*NDIM +: NDIM]   = m_addr[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 1; i <= NBUF; i++) begin
            m_valid[i] = 1'b0;
            m_pri[i]   = '0;
            m_addr[i]  = '0;
        end
    endtask

    // Highest priority among valid buffers with address bit d set; lowest index on ties.
    function automatic int ref_pick(int d);
        int best;
        int bp;
        int p;
        best = 0;
        bp   = 0;
        for (int i = 1; i <= NBUF; i++) begin
            p = (m_valid[i] && m_addr[i][d]) ? int'(m_pri[i]) : 0;
            if (p > bp) begin
                bp   = p;
                best = i;
            end
        end
        return best;
    endfunction

    // Entered with the DUT in its pick cycle. mode: 0 ready at offer cycle k,
    // 1 never ready (timeout), 2 valid drops at k, 3 valid drops with ready at k.
    task automatic visit(input int mode, input int k, input bit stop);
        int exp_sel;
        int o;
        bit xfer;
        bit blk;
        bit done;
        drive();
        exp_sel = ref_pick(m_dim);
        chk("pick_cur_dim", 32'(bus.cur_dim), 32'(m_dim));
        @(posedge clk); #1;
        xfer = 1'b0;
        blk  = 1'b0;
        if (exp_sel != 0) begin
            for (int c = 0; c < TIMEOUT; c++) begin
                chk("offer_valid", 32'(bus.send_valid), 32'd1);
                chk("offer_buf", 32'(bus.send_buf), 32'(exp_sel));
                if (stop && c == 0) bus.en = 1'b0;
                o = int'($urandom_range(1, NBUF));
                if (o != exp_sel) m_pri[o] = 3'($urandom_range(0, 7));
                done = 1'b0;
                if ((mode == 0 || mode == 3) && c == k) begin
                    bus.send_ready = 1'b1;
                    xfer = 1'b1;
                    done = 1'b1;
                end
                if ((mode == 2 || mode == 3) && c == k) begin
                    m_valid[exp_sel] = 1'b0;
                    done = 1'b1;
                end
                if (mode == 1 && c == TIMEOUT - 1) begin
                    blk  = 1'b1;
                    done = 1'b1;
                end
                drive();
                @(posedge clk); #1;
                bus.send_ready = 1'b0;
                if (done) break;
            end
        end
        chk("adv_send_valid", 32'(bus.send_valid), 32'd0);
        chk("adv_send_buf", 32'(bus.send_buf), 32'd0);
        chk("clr_valid", 32'(bus.clr_valid), 32'(xfer));
        if (xfer) begin
            chk("clr_buf", 32'(bus.clr_buf), 32'(exp_sel));
            chk("clr_dim", 32'(bus.clr_dim), 32'(m_dim));
            m_addr[exp_sel][m_dim] = 1'b0;
        end
        chk("blocked", 32'(bus.blocked), 32'(blk));
        chk("cycle_done", 32'(bus.cycle_done), 32'(m_dim == NDIM - 1));
        m_dim = (m_dim + 1) % NDIM;
        drive();
        @(posedge clk); #1;
        if (stop) begin
            for (int c = 0; c < 3; c++) begin
                chk("stopped_no_offer", 32'(bus.send_valid), 32'd0);
                chk("stopped_dim_hold", 32'(bus.cur_dim), 32'(m_dim));
                @(posedge clk); #1;
            end
            bus.en = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.send_ready = 1'b0;
        bus.buf_valid = '0;
        bus.buf_pri = '0;
        bus.buf_addr = '0;
        clear_model();
        m_dim = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cur_dim", 32'(bus.cur_dim), 32'd0);
        chk("rst_send_valid", 32'(bus.send_valid), 32'd0);
        chk("rst_send_buf", 32'(bus.send_buf), 32'd0);
        chk("rst_clr_valid", 32'(bus.clr_valid), 32'd0);
        chk("rst_clr_buf", 32'(bus.clr_buf), 32'd0);
        chk("rst_clr_dim", 32'(bus.clr_dim), 32'd0);
        chk("rst_blocked", 32'(bus.blocked), 32'd0);
        chk("rst_cycle_done", 32'(bus.cycle_done), 32'd0);

        rst_n = 1'b1;
        m_valid[3] = 1'b1;
        m_pri[3]   = 3'd5;
        m_addr[3]  = 12'h001;
        bus.send_ready = 1'b1;
        drive();
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_no_offer", 32'(bus.send_valid), 32'd0);
            chk("idle_dim", 32'(bus.cur_dim), 32'd0);
        end
        bus.send_ready = 1'b0;

        // Single transfer at dim 0 from buffer 3.
        bus.en = 1'b1;
        @(posedge clk); #1;
        visit(0, 0, 1'b0);

        // Tie at dim 1: buffers 2 and 6 eligible, buffer 5 same priority but bit clear.
        clear_model();
        m_valid[2] = 1'b1; m_pri[2] = 3'd4; m_addr[2] = 12'h002;
        m_valid[6] = 1'b1; m_pri[6] = 3'd4; m_addr[6] = 12'h002;
        m_valid[5] = 1'b1; m_pri[5] = 3'd4; m_addr[5] = 12'h001;
        visit(0, 2, 1'b0);

        // Timeout at dim 2, re-offer at dim 5.
        clear_model();
        m_valid[1] = 1'b1; m_pri[1] = 3'd1; m_addr[1] = 12'h024;
        visit(1, 0, 1'b0);
        visit(0, 0, 1'b0);
        visit(0, 0, 1'b0);
        visit(0, 3, 1'b0);

        // Withdraw at dim 6, then withdraw racing a ready at dim 7.
        clear_model();
        m_valid[4] = 1'b1; m_pri[4] = 3'd6; m_addr[4] = 12'h0C0;
        visit(2, 4, 1'b0);
        m_valid[4] = 1'b1;
        visit(3, 1, 1'b0);

        // en drops during an offer at dim 8: offer completes, scheduler then idles.
        clear_model();
        m_valid[7] = 1'b1; m_pri[7] = 3'd2; m_addr[7] = 12'h100;
        visit(0, 2, 1'b1);

        // Empty sweeps from a fresh reset: 2 cycles per dimension.
        clear_model();
        drive();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.en = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int t = 0; t < 60; t++) begin
            chk("sweep_dim", 32'(bus.cur_dim), 32'((t / 2) % NDIM));
            chk("sweep_cycle_done", 32'(bus.cycle_done), 32'((t % 24) == 23));
            chk("sweep_no_offer", 32'(bus.send_valid), 32'd0);
            if (bus.cycle_done) ndone++;
            @(posedge clk); #1;
        end
        chk("sweep_done_count", 32'(ndone), 32'd2);

        // Reset asserted during an offer at dim 6.
        m_valid[1] = 1'b1; m_pri[1] = 3'd3; m_addr[1] = 12'h040;
        drive();
        @(posedge clk); #1;
        chk("pre_rst_offer_valid", 32'(bus.send_valid), 32'd1);
        chk("pre_rst_offer_buf", 32'(bus.send_buf), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_send_valid", 32'(bus.send_valid), 32'd0);
        chk("async_rst_send_buf", 32'(bus.send_buf), 32'd0);
        chk("async_rst_cur_dim", 32'(bus.cur_dim), 32'd0);
        @(posedge clk); #1;
        bus.en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(bus.send_valid), 32'd0);
        chk("post_rst_dim", 32'(bus.cur_dim), 32'd0);
        bus.en = 1'b1;
        @(posedge clk); #1;
        m_dim = 0;

        // Randomized visits.
        for (int v = 0; v < 150; v++) begin
            for (int i = 1; i <= NBUF; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    m_valid[i] = 1'($urandom_range(0, 1));
                    m_pri[i]   = 3'($urandom_range(0, 7));
                    m_addr[i]  = 12'($urandom);
                end
            end
            visit(int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
